// File: rtl/drive_seq_pkg.sv
// Shared types and default widths for the drive pulse sequencer and its NCO.
package drive_seq_pkg;

  localparam int unsigned DefEnveMemNumEntry  = 1024;
  localparam int unsigned DefEnveMemAddrWidth = 10;
  localparam int unsigned DefPhaseWidth       = 10;
  localparam int unsigned DefAmpWidth         = 8;
  localparam int unsigned DefNcoAccWidth      = 22;
  localparam int unsigned DefPulseLenWidth    = 10;

  // Envelope memory word is {phase, amp}: amp in the LSBs, phase directly above it.
  localparam int unsigned MemAmpLsb = 0;

  typedef enum logic [0:0] {
    StIdle,
    StRun
  } seq_state_e;

endpackage

// File: rtl/nco_phase_accumulator.sv
// Free-running phase accumulator with loadable frequency word and synchronous phase clear.
module nco_phase_accumulator #(
  parameter int unsigned NCO_ACC_WIDTH = 22,
  parameter int unsigned PHASE_WIDTH   = 10
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_freq_wr_en,
  input  logic [NCO_ACC_WIDTH-1:0] i_freq_wr_data,
  input  logic                     i_phase_sync,
  output logic [PHASE_WIDTH-1:0]   o_phase
);

  logic [NCO_ACC_WIDTH-1:0] r_freq;
  logic [NCO_ACC_WIDTH-1:0] r_acc;

  // A new frequency word only affects the increment after the edge that loads it.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_freq <= '0;
      r_acc  <= '0;
    end else begin
      if (i_freq_wr_en) begin
        r_freq <= i_freq_wr_data;
      end
      if (i_phase_sync) begin
        r_acc <= '0;
      end else begin
        r_acc <= r_acc + r_freq;
      end
    end
  end

  assign o_phase = r_acc[NCO_ACC_WIDTH-1 -: PHASE_WIDTH];

endmodule

// File: rtl/drive_pulse_sequencer.sv
// Pulse command sequencer: walks the envelope memory per command and emits
// phase-aligned {nco_phase, envelope phase, amplitude} samples with fixed latency 2.
module drive_pulse_sequencer
  import drive_seq_pkg::*;
#(
  parameter int unsigned ENVE_MEM_NUM_ENTRY  = DefEnveMemNumEntry,
  parameter int unsigned ENVE_MEM_ADDR_WIDTH = DefEnveMemAddrWidth,
  parameter int unsigned PHASE_WIDTH         = DefPhaseWidth,
  parameter int unsigned AMP_WIDTH           = DefAmpWidth,
  parameter int unsigned NCO_ACC_WIDTH       = DefNcoAccWidth,
  parameter int unsigned PULSE_LEN_WIDTH     = DefPulseLenWidth
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           freq_wr_en,
  input  logic [NCO_ACC_WIDTH-1:0]       freq_wr_data,
  input  logic                           phase_sync,
  input  logic                           cmd_valid,
  output logic                           cmd_ready,
  input  logic [ENVE_MEM_ADDR_WIDTH-1:0] cmd_start_addr,
  input  logic [PULSE_LEN_WIDTH-1:0]     cmd_length,
  input  logic [PHASE_WIDTH-1:0]         cmd_phase_offset,
  output logic [ENVE_MEM_ADDR_WIDTH-1:0] enve_mem_rd_addr_out,
  input  logic [PHASE_WIDTH+AMP_WIDTH-1:0] enve_mem_rd_data_in,
  output logic [PHASE_WIDTH-1:0]         nco_phase,
  output logic [PHASE_WIDTH-1:0]         enve_memory_phase,
  output logic [AMP_WIDTH-1:0]           enve_memory_amp,
  output logic                           valid_out,
  output logic                           busy
);

  localparam logic [ENVE_MEM_ADDR_WIDTH-1:0] LastAddr =
    ENVE_MEM_ADDR_WIDTH'(ENVE_MEM_NUM_ENTRY - 1);

  seq_state_e                     r_state, w_state_next;
  logic [ENVE_MEM_ADDR_WIDTH-1:0] r_rd_addr, w_rd_addr_next;
  logic [PULSE_LEN_WIDTH-1:0]     r_remaining, w_remaining_next;
  logic [PHASE_WIDTH-1:0]         r_offset, w_offset_next;

  logic                   r_mem_vld;
  logic [PHASE_WIDTH-1:0] r_mem_offset;
  logic                   r_valid_out;
  logic [PHASE_WIDTH-1:0] r_nco_phase;
  logic [PHASE_WIDTH-1:0] r_enve_phase;
  logic [AMP_WIDTH-1:0]   r_enve_amp;

  logic                   w_last;
  logic                   w_accept;
  logic                   w_start;
  logic [PHASE_WIDTH-1:0] w_acc_phase;
  logic [PHASE_WIDTH-1:0] w_mem_phase;
  logic [AMP_WIDTH-1:0]   w_mem_amp;

  nco_phase_accumulator #(
    .NCO_ACC_WIDTH (NCO_ACC_WIDTH),
    .PHASE_WIDTH   (PHASE_WIDTH)
  ) u_nco (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_freq_wr_en   (freq_wr_en),
    .i_freq_wr_data (freq_wr_data),
    .i_phase_sync   (phase_sync),
    .o_phase        (w_acc_phase)
  );

  assign w_last    = (r_state == StRun) && (r_remaining == '0);
  assign cmd_ready = !rst && ((r_state == StIdle) || w_last);
  assign w_accept  = cmd_valid && cmd_ready;
  assign w_start   = w_accept && (cmd_length != '0);

  always_comb begin
    w_state_next     = r_state;
    w_rd_addr_next   = r_rd_addr;
    w_remaining_next = r_remaining;
    w_offset_next    = r_offset;
    if (r_state == StRun) begin
      w_rd_addr_next = (r_rd_addr == LastAddr) ? '0 : r_rd_addr + ENVE_MEM_ADDR_WIDTH'(1);
      if (w_last) begin
        w_state_next = StIdle;
      end else begin
        w_remaining_next = r_remaining - PULSE_LEN_WIDTH'(1);
      end
    end
    // A command accepted on the final address cycle takes over with no bubble.
    if (w_start) begin
      w_state_next     = StRun;
      w_rd_addr_next   = cmd_start_addr;
      w_remaining_next = cmd_length - PULSE_LEN_WIDTH'(1);
      w_offset_next    = cmd_phase_offset;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= StIdle;
      r_rd_addr   <= '0;
      r_remaining <= '0;
      r_offset    <= '0;
    end else begin
      r_state     <= w_state_next;
      r_rd_addr   <= w_rd_addr_next;
      r_remaining <= w_remaining_next;
      r_offset    <= w_offset_next;
    end
  end

  assign w_mem_amp   = enve_mem_rd_data_in[MemAmpLsb +: AMP_WIDTH];
  assign w_mem_phase = enve_mem_rd_data_in[AMP_WIDTH +: PHASE_WIDTH];

  // The offset rides along with its address so back-to-back pulses keep their own offsets.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem_vld    <= 1'b0;
      r_mem_offset <= '0;
      r_valid_out  <= 1'b0;
      r_nco_phase  <= '0;
      r_enve_phase <= '0;
      r_enve_amp   <= '0;
    end else begin
      r_mem_vld    <= (r_state == StRun);
      r_mem_offset <= r_offset;
      r_valid_out  <= r_mem_vld;
      r_nco_phase  <= w_acc_phase;
      if (r_mem_vld) begin
        r_enve_phase <= w_mem_phase + r_mem_offset;
        r_enve_amp   <= w_mem_amp;
      end else begin
        r_enve_phase <= '0;
        r_enve_amp   <= '0;
      end
    end
  end

  assign enve_mem_rd_addr_out = r_rd_addr;
  assign nco_phase            = r_nco_phase;
  assign enve_memory_phase    = r_enve_phase;
  assign enve_memory_amp      = r_enve_amp;
  assign valid_out            = r_valid_out;
  assign busy                 = (r_state == StRun) || r_mem_vld || r_valid_out;

endmodule

// File: tb/tb_drive_pulse_sequencer.sv
// Scoreboard bench for drive_pulse_sequencer: directed scenarios plus randomized commands.
module tb_drive_pulse_sequencer;

  localparam int NumEntry = 1024;
  localparam int PhaseMod = 1024;
  localparam int AccMod   = 4194304;
  localparam int AccShift = 4096;

  logic        clk = 1'b0;
  logic        rst;
  logic        freq_wr_en;
  logic [21:0] freq_wr_data;
  logic        phase_sync;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [9:0]  cmd_start_addr;
  logic [9:0]  cmd_length;
  logic [9:0]  cmd_phase_offset;
  logic [9:0]  enve_mem_rd_addr_out;
  logic [17:0] enve_mem_rd_data_in;
  logic [9:0]  nco_phase;
  logic [9:0]  enve_memory_phase;
  logic [7:0]  enve_memory_amp;
  logic        valid_out;
  logic        busy;

  drive_pulse_sequencer dut (
    .clk                  (clk),
    .rst                  (rst),
    .freq_wr_en           (freq_wr_en),
    .freq_wr_data         (freq_wr_data),
    .phase_sync           (phase_sync),
    .cmd_valid            (cmd_valid),
    .cmd_ready            (cmd_ready),
    .cmd_start_addr       (cmd_start_addr),
    .cmd_length           (cmd_length),
    .cmd_phase_offset     (cmd_phase_offset),
    .enve_mem_rd_addr_out (enve_mem_rd_addr_out),
    .enve_mem_rd_data_in  (enve_mem_rd_data_in),
    .nco_phase            (nco_phase),
    .enve_memory_phase    (enve_memory_phase),
    .enve_memory_amp      (enve_memory_amp),
    .valid_out            (valid_out),
    .busy                 (busy)
  );

  always #5 clk = ~clk;

  // Synchronous envelope memory: word at address a is {a, (2*a) mod 256}.
  always @(posedge clk) begin
    enve_mem_rd_data_in <= {enve_mem_rd_addr_out, 8'(enve_mem_rd_addr_out << 1)};
  end

  typedef struct {
    int cyc;
    int acc_edge;
    int amp;
    int phase;
  } sb_entry_t;

  sb_entry_t sb[$];
  int        n_checks = 0;
  int        n_fail   = 0;
  int        cyc      = 0;
  int        run_end  = 0;
  bit        chk_en   = 1'b0;

  longint m_acc   = 0;
  longint m_freq  = 0;
  int     exp_nco = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
  end

  // NCO reference: output phase is the accumulator's top bits as seen just before each edge.
  always @(posedge clk) begin
    if (rst) begin
      m_acc   <= 0;
      m_freq  <= 0;
      exp_nco <= 0;
    end else begin
      exp_nco <= int'(m_acc / AccShift);
      m_acc   <= phase_sync ? 0 : (m_acc + m_freq) % AccMod;
      if (freq_wr_en) m_freq <= longint'(freq_wr_data);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  sb_entry_t mon_e;
  bit        mon_busy;

  always @(negedge clk) begin
    #2;
    if (chk_en) begin
      mon_busy = (sb.size() > 0) && (sb[0].acc_edge <= cyc);
      check("busy", 32'(busy), 32'(mon_busy));
      check("cmd_ready", 32'(cmd_ready), 32'(!rst && (cyc >= run_end - 1)));
      check("nco_phase", 32'(nco_phase), exp_nco);
      if (valid_out === 1'b1) begin
        if (sb.size() == 0) begin
          check("unexpected_valid", 32'(valid_out), 0);
        end else begin
          mon_e = sb.pop_front();
          check("sample_cycle", cyc, mon_e.cyc);
          check("enve_amp", 32'(enve_memory_amp), mon_e.amp);
          check("enve_phase", 32'(enve_memory_phase), mon_e.phase);
        end
      end else begin
        check("idle_amp", 32'(enve_memory_amp), 0);
        check("idle_phase", 32'(enve_memory_phase), 0);
        if (sb.size() > 0 && sb[0].cyc <= cyc) begin
          mon_e = sb.pop_front();
          check("missing_valid", 32'(valid_out), 1);
        end
      end
    end
  end

  // Called at a negedge; returns at a negedge.
  task automatic idle(input int n, input bit rnd);
    repeat (n) begin
      if (rnd) begin
        phase_sync   = ($urandom_range(0, 9) == 0);
        freq_wr_en   = ($urandom_range(0, 7) == 0);
        freq_wr_data = 22'($urandom());
      end
      @(negedge clk);
    end
    phase_sync = 1'b0;
    freq_wr_en = 1'b0;
  endtask

  task automatic send_cmd(input int start, input int len, input int off);
    int        k;
    int        waited;
    bit        accepted;
    sb_entry_t e;
    cmd_valid        = 1'b1;
    cmd_start_addr   = 10'(start);
    cmd_length       = 10'(len);
    cmd_phase_offset = 10'(off);
    waited   = 0;
    accepted = 1'b0;
    while (!accepted && waited < 100) begin
      #1;
      if (cmd_ready === 1'b1) begin
        k = cyc;
        @(posedge clk);
        for (int i = 0; i < len; i++) begin
          e.acc_edge = k + 1;
          e.cyc      = k + 3 + i;
          e.amp      = (((start + i) % NumEntry) * 2) % 256;
          e.phase    = (((start + i) % NumEntry) + off) % PhaseMod;
          sb.push_back(e);
        end
        if (len > 0) run_end = k + 1 + len;
        accepted = 1'b1;
      end
      @(negedge clk);
      waited++;
    end
    cmd_valid = 1'b0;
    if (!accepted) check("cmd_accept_timeout", 32'(accepted), 1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() > 0 || busy !== 1'b0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) check("drain_timeout", n, 0);
    idle(2, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    sb.delete();
    run_end = 0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n1;
    rst = 1'b1;
    freq_wr_en = 1'b0;
    freq_wr_data = '0;
    phase_sync = 1'b0;
    cmd_valid = 1'b0;
    cmd_start_addr = '0;
    cmd_length = '0;
    cmd_phase_offset = '0;

    @(negedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    rst = 1'b0;

    // Frequency 2**12: nco phase steps by one per cycle.
    freq_wr_en   = 1'b1;
    freq_wr_data = 22'(4096);
    @(negedge clk);
    freq_wr_en = 1'b0;
    idle(4, 1'b0);
    #3;
    n1 = int'(nco_phase);
    @(negedge clk);
    #3;
    check("nco_step", 32'((int'(nco_phase) - n1 + PhaseMod) % PhaseMod), 1);
    @(negedge clk);
    idle(4, 1'b0);

    send_cmd(5, 4, 0);
    drain();
    send_cmd(1022, 4, 1020);
    drain();
    send_cmd(10, 3, 0);
    send_cmd(20, 3, 512);
    drain();
    send_cmd(100, 0, 7);
    send_cmd(200, 2, 3);
    drain();

    // phase_sync mid-pulse, then reset on the 2nd sample of a length-8 pulse.
    send_cmd(300, 8, 0);
    phase_sync = 1'b1;
    @(negedge clk);
    phase_sync = 1'b0;
    @(negedge clk);
    @(negedge clk);
    do_reset();
    idle(12, 1'b0);

    for (int t = 0; t < 40; t++) begin
      send_cmd(int'($urandom_range(0, 1023)), int'($urandom_range(0, 12)),
               int'($urandom_range(0, 1023)));
      if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 4)), 1'b1);
    end
    drain();
    check("scoreboard_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
